i2c_rtc_target: RTL and testbench

//   I2C target (responder) presenting an 8-byte BCD datetime register file at a

---
 rtl/i2c_rtc_target.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_i2c_rtc_target.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_rtc_target.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_rtc_target
//  Description : I2C target presenting an 8-byte BCD datetime register file
//                (MCP7940N-compatible map 0x00-0x07) at a fixed 7-bit address.
//                The local host may preload/update registers; bytes written
//                over I2C are reported with a one-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_rtc_target #(
  parameter logic [6:0] c_addr = 7'h6F,
  parameter int         c_sync = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_wr,
  input  logic [2:0]  host_addr,
  input  logic [7:0]  host_data,
  output logic [63:0] regs_o,
  output logic        i2c_wr,
  output logic [2:0]  i2c_wr_addr,
  output logic        busy,
  input  logic        scl,
  inout  wire         sda
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RACK      = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  // Input synchronisers and one-cycle delayed copies for edge detection
  logic [c_sync-1:0] scl_sync_q;
  logic [c_sync-1:0] sda_sync_q;
  logic              scl_prev_q;
  logic              sda_prev_q;

  // Protocol state
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  ptr_q, ptr_d;
  logic        sda_low_q, sda_low_d;
  logic        busy_q, busy_d;
  logic        wr_q, wr_d;
  logic [2:0]  wr_addr_q, wr_addr_d;
  logic [63:0] regs_q, regs_d;

  logic        w_scl;
  logic        w_sda;
  logic        w_rise;
  logic        w_fall;
  logic        w_start;
  logic        w_stop;
  logic [7:0]  w_byte;
  logic [7:0]  w_rd_byte;
  logic        w_i2c_we;

  // Open-drain output: only ever pull low or release
  assign sda = sda_low_q ? 1'b0 : 1'bz;

  assign w_scl   = scl_sync_q[c_sync-1];
  assign w_sda   = sda_sync_q[c_sync-1];
  assign w_rise  = w_scl & ~scl_prev_q;
  assign w_fall  = ~w_scl & scl_prev_q;
  // Bus conditions need scl high on both samples so an scl edge is never
  // mistaken for a START/STOP.
  assign w_start = w_scl & scl_prev_q & sda_prev_q & ~w_sda;
  assign w_stop  = w_scl & scl_prev_q & ~sda_prev_q & w_sda;

  // Byte as it stands including the bit being sampled on this scl rise
  assign w_byte    = {shift_q[6:0], w_sda};
  assign w_rd_byte = regs_q[{ptr_q, 3'b000} +: 8];

  assign regs_o      = regs_q;
  assign i2c_wr      = wr_q;
  assign i2c_wr_addr = wr_addr_q;
  assign busy        = busy_q;

  // Synchronise scl/sda into the clk domain; idle bus level is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[c_sync-2:0], scl};
      sda_sync_q <= {sda_sync_q[c_sync-2:0], sda};
      scl_prev_q <= w_scl;
      sda_prev_q <= w_sda;
    end
  end

  // Protocol FSM next-state, bus drive and register file update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_low_d = sda_low_q;
    busy_d    = busy_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    w_i2c_we  = 1'b0;

    if (w_stop) begin
      state_d   = S_IDLE;
      cnt_d     = 3'd0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (w_start) begin
      // Repeated START keeps busy; the address byte decides what follows
      state_d   = S_ADDR;
      cnt_d     = 3'd0;
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sda_low_d = 1'b0;
        end

        S_ADDR: begin
          if (w_rise) begin
            shift_d = w_byte;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (w_byte[7:1] == c_addr) begin
                state_d = S_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = S_IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        // First fall asserts ACK; second fall (ACK already driven) ends it.
        // shift_q[0] still holds the R/W bit of the address byte.
        S_ADDR_ACK: begin
          if (w_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else if (shift_q[0]) begin
              shift_d   = w_rd_byte;
              sda_low_d = ~w_rd_byte[7];
              cnt_d     = 3'd0;
              state_d   = S_RDATA;
            end else begin
              sda_low_d = 1'b0;
              cnt_d     = 3'd0;
              state_d   = S_PTR;
            end
          end
        end

        S_PTR: begin
          if (w_rise) begin
            shift_d = w_byte;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ptr_d   = w_byte[2:0];
              state_d = S_PTR_ACK;
            end
          end
        end

        S_PTR_ACK, S_WDATA_ACK: begin
          if (w_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              cnt_d     = 3'd0;
              state_d   = S_WDATA;
            end
          end
        end

        S_WDATA: begin
          if (w_rise) begin
            shift_d = w_byte;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              w_i2c_we  = 1'b1;
              wr_d      = 1'b1;
              wr_addr_d = ptr_q;
              ptr_d     = ptr_q + 3'd1;
              state_d   = S_WDATA_ACK;
            end
          end
        end

        // Bit 7 is already on the bus at entry; each rise consumes one bit
        // and each fall presents the next.
        S_RDATA: begin
          if (w_rise) begin
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ptr_d   = ptr_q + 3'd1;
              state_d = S_RACK;
            end
          end else if (w_fall) begin
            sda_low_d = ~shift_q[7];
          end
        end

        // Release after the last data bit, then sample the initiator's ACK
        S_RACK: begin
          if (w_fall) begin
            sda_low_d = 1'b0;
          end else if (w_rise) begin
            if (!w_sda) begin
              shift_d = w_rd_byte;
              cnt_d   = 3'd0;
              state_d = S_RDATA;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IGNORE;
            end
          end
        end

        S_IGNORE: begin
          sda_low_d = 1'b0;
        end

        default: begin
          state_d   = S_IDLE;
          sda_low_d = 1'b0;
        end
      endcase
    end

    // I2C write is applied last so it wins a same-index collision
    regs_d = regs_q;
    if (host_wr) begin
      regs_d[{host_addr, 3'b000} +: 8] = host_data;
    end
    if (w_i2c_we) begin
      regs_d[{ptr_q, 3'b000} +: 8] = w_byte;
    end
  end

  // State and register file; reset releases sda immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      shift_q   <= 8'd0;
      ptr_q     <= 3'd0;
      sda_low_q <= 1'b0;
      busy_q    <= 1'b0;
      wr_q      <= 1'b0;
      wr_addr_q <= 3'd0;
      regs_q    <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_low_q <= sda_low_d;
      busy_q    <= busy_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      regs_q    <= regs_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_rtc_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_rtc_target
//  Description : Directed self-checking bench for i2c_rtc_target acting as
//                an I2C initiator with hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_rtc_target;

  localparam int c_q = 8;  // clk cycles per quarter SCL period

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        host_wr   = 1'b0;
  logic [2:0]  host_addr = 3'd0;
  logic [7:0]  host_data = 8'd0;
  logic [63:0] regs_o;
  logic        i2c_wr;
  logic [2:0]  i2c_wr_addr;
  logic        busy;
  logic        scl       = 1'b1;
  logic        tb_sda_low = 1'b0;
  wire         sda;

  pullup (sda);
  assign sda = tb_sda_low ? 1'b0 : 1'bz;

  int n_checks = 0;
  int n_errors = 0;

  int         wr_cnt = 0;
  logic [2:0] wr_log [16];

  logic [2:0] inj_addr = 3'd0;
  logic [7:0] inj_data = 8'd0;

  always #5 clk = ~clk;

  i2c_rtc_target dut (
    .clk         (clk),
    .reset       (reset),
    .host_wr     (host_wr),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .regs_o      (regs_o),
    .i2c_wr      (i2c_wr),
    .i2c_wr_addr (i2c_wr_addr),
    .busy        (busy),
    .scl         (scl),
    .sda         (sda)
  );

  // Log every i2c_wr pulse and its index
  always @(negedge clk) begin
    if (i2c_wr === 1'b1) begin
      if (wr_cnt < 16) wr_log[wr_cnt] = i2c_wr_addr;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    host_addr = a;
    host_data = d;
    host_wr   = 1'b1;
    tick(1);
    host_wr   = 1'b0;
  endtask

  task automatic i2c_start();
    tb_sda_low = 1'b0;
    tick(c_q);
    scl = 1'b1;
    tick(c_q);
    tb_sda_low = 1'b1;
    tick(c_q);
    scl = 1'b0;
    tick(c_q);
  endtask

  task automatic i2c_stop();
    tb_sda_low = 1'b1;
    tick(c_q);
    scl = 1'b1;
    tick(c_q);
    tb_sda_low = 1'b0;
    tick(c_q);
  endtask

  // inj: pulse host_wr in the same clk as the target's 8th-bit sampling
  task automatic write_bit(input logic b, input bit inj);
    tb_sda_low = ~b;
    tick(c_q);
    scl = 1'b1;
    if (inj) begin
      tick(2);
      host_addr = inj_addr;
      host_data = inj_data;
      host_wr   = 1'b1;
      tick(1);
      host_wr   = 1'b0;
      tick(2 * c_q - 3);
    end else begin
      tick(2 * c_q);
    end
    scl = 1'b0;
    tick(c_q);
  endtask

  task automatic read_bit(output logic b);
    tb_sda_low = 1'b0;
    tick(c_q);
    scl = 1'b1;
    tick(c_q);
    b = (sda === 1'b0) ? 1'b0 : 1'b1;
    tick(c_q);
    scl = 1'b0;
    tick(c_q);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit inj, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], inj && (i == 0));
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;

    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_regs",  regs_o, 64'd0);
    check("rst_busy",  busy, 1'b0);
    check("rst_wr",    i2c_wr, 1'b0);
    check("rst_wradr", i2c_wr_addr, 3'd0);
    check("rst_sda",   sda === 1'b0, 1'b0);

    // 1: write two bytes starting at r2
    i2c_start();
    write_byte(8'hDE, 1'b0, ack); check("t1_ack_addr", ack, 1'b0);
    write_byte(8'h02, 1'b0, ack); check("t1_ack_ptr", ack, 1'b0);
    check("t1_busy_mid", busy, 1'b1);
    write_byte(8'h45, 1'b0, ack); check("t1_ack_d0", ack, 1'b0);
    write_byte(8'h23, 1'b0, ack); check("t1_ack_d1", ack, 1'b0);
    i2c_stop();
    tick(4);
    check("t1_regs",   regs_o, 64'h0000_0000_2345_0000);
    check("t1_wrcnt",  wr_cnt, 2);
    check("t1_wradr0", wr_log[0], 3'd2);
    check("t1_wradr1", wr_log[1], 3'd3);
    check("t1_busy",   busy, 1'b0);

    // 2: host preload, then read three bytes across the 7->0 wrap
    host_write(3'd6, 8'h11);
    host_write(3'd7, 8'h22);
    host_write(3'd0, 8'h33);
    tick(1);
    check("t2_preload", regs_o, 64'h2211_0000_2345_0033);
    i2c_start();
    write_byte(8'hDE, 1'b0, ack); check("t2_ack_addw", ack, 1'b0);
    write_byte(8'h06, 1'b0, ack); check("t2_ack_ptr", ack, 1'b0);
    i2c_start();
    write_byte(8'hDF, 1'b0, ack); check("t2_ack_addr", ack, 1'b0);
    read_byte(1'b0, rd); check("t2_rd0", rd, 8'h11);
    read_byte(1'b0, rd); check("t2_rd1", rd, 8'h22);
    read_byte(1'b1, rd); check("t2_rd2", rd, 8'h33);
    tick(4);
    check("t2_sda_rel", sda === 1'b0, 1'b0);
    check("t2_busy",    busy, 1'b0);
    i2c_stop();

    // 3: foreign address is not acknowledged
    i2c_start();
    write_byte(8'hA0, 1'b0, ack); check("t3_nack", ack, 1'b1);
    check("t3_busy", busy, 1'b0);
    i2c_stop();
    check("t3_regs", regs_o, 64'h2211_0000_2345_0033);

    // 4: pointer upper bits ignored
    i2c_start();
    write_byte(8'hDE, 1'b0, ack); check("t4_ack_addr", ack, 1'b0);
    write_byte(8'hFB, 1'b0, ack); check("t4_ack_ptr", ack, 1'b0);
    write_byte(8'h59, 1'b0, ack); check("t4_ack_d", ack, 1'b0);
    i2c_stop();
    tick(4);
    check("t4_regs",  regs_o, 64'h2211_0000_5945_0033);
    check("t4_wrcnt", wr_cnt, 3);
    check("t4_wradr", wr_log[2], 3'd3);

    // 6: host/I2C collisions, then STOP mid-byte
    i2c_start();
    write_byte(8'hDE, 1'b0, ack);
    write_byte(8'h04, 1'b0, ack);
    inj_addr = 3'd4; inj_data = 8'hAA;
    write_byte(8'h55, 1'b1, ack); check("t6_ack_same", ack, 1'b0);
    inj_addr = 3'd1; inj_data = 8'h77;
    write_byte(8'h66, 1'b1, ack); check("t6_ack_diff", ack, 1'b0);
    i2c_stop();
    tick(4);
    check("t6_regs",   regs_o, 64'h2211_6655_5945_7733);
    check("t6_wrcnt",  wr_cnt, 5);
    check("t6_wradr3", wr_log[3], 3'd4);
    check("t6_wradr4", wr_log[4], 3'd5);
    i2c_start();
    write_byte(8'hDE, 1'b0, ack);
    write_byte(8'h00, 1'b0, ack);
    write_bit(1'b1, 1'b0);
    write_bit(1'b0, 1'b0);
    write_bit(1'b1, 1'b0);
    write_bit(1'b0, 1'b0);
    i2c_stop();
    tick(4);
    check("t6_part_wrcnt", wr_cnt, 5);
    check("t6_part_regs",  regs_o, 64'h2211_6655_5945_7733);
    check("t6_part_busy",  busy, 1'b0);

    // 5: reset while the target is pulling sda low for a 0 data bit
    i2c_start();
    write_byte(8'hDE, 1'b0, ack);
    write_byte(8'h00, 1'b0, ack);
    i2c_start();
    write_byte(8'hDF, 1'b0, ack); check("t5_ack_addr", ack, 1'b0);
    check("t5_driving", sda === 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    check("t5_sda_rel", sda === 1'b0, 1'b0);
    check("t5_regs",    regs_o, 64'd0);
    check("t5_busy",    busy, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(2);
    i2c_stop();
    tick(4);
    check("t5_wr",   i2c_wr, 1'b0);
    check("t5_post", regs_o, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
